uart_tx_queue: RTL
==================

// Module: uart_tx_queue
// PURPOSE
//  Byte FIFO and transmit sequencer placed directly upstream of the UART top-level.
//  Producers push bytes at any rate up to one per clock.
//  The block issues each byte to the UART transmitter through its wr_en / data_in /
//  busy handshake, one byte at a time, in push order. No byte is lost while the
//  transmitter is busy.
// PARAMETERS
//  DEPTH         16  FIFO entries; power of two, >= 2
//  BUSY_TIMEOUT  8   clocks to wait for tx_busy to rise after tx_wr_en before re-issuing
// PORTS
//  clk         in   1  system clock, all logic on rising edge
//  rst         in   1  synchronous, active-high reset
//  push        in   1  write push_data into FIFO this cycle
//  push_data   in   8  byte to queue
//  full        out  1  FIFO holds DEPTH entries
//  empty       out  1  FIFO holds 0 entries
//  overflow    out  1  one-cycle pulse: push while full, byte dropped
//  tx_wr_en    out  1  to UART wr_en; single-cycle pulse per issue
//  tx_data     out  8  to UART data_in; stable from issue until tx_busy falls
//  tx_busy     in   1  from UART busy
//  idle        out  1  FIFO empty and FSM in IDLE
// BEHAVIOUR
//  Reset values: full=0, empty=1, overflow=0, tx_wr_en=0, tx_data=8'h00, idle=1.
//  Reset also clears pointers, count, timeout counter and FSM (->IDLE), mid-operation included.
//  FIFO: circular buffer; pointers are log2(DEPTH) bits and wrap modulo DEPTH.
//  count is log2(DEPTH)+1 bits. full/empty are registered from count.
//  Push: accepted when !full. A push while full is dropped and pulses overflow for one
//   cycle, even if a pop occurs in the same cycle.
//  Pop: occurs only on the WAIT_BUSY->WAIT_DONE transition. Simultaneous accepted push
//   and pop leaves count unchanged.
//  FSM, registered outputs:
//   IDLE      : if !empty && !tx_busy -> ISSUE; tx_data <= head entry
//   ISSUE     : tx_wr_en=1 for exactly this cycle; clear timer -> WAIT_BUSY
//   WAIT_BUSY : tx_busy=1 -> pop head, -> WAIT_DONE
//               timer reaches BUSY_TIMEOUT -> ISSUE (same byte re-issued, no pop)
//   WAIT_DONE : tx_busy=0 -> IDLE
//  Latency: a push into an empty FIFO with tx_busy=0 gives tx_wr_en=1 two cycles later
//   (push edge N, IDLE sees !empty at N+1, ISSUE at N+2).
//  Back-to-back: the next issue occurs no earlier than 2 cycles after tx_busy falls.
//  tx_data holds its value from ISSUE through WAIT_DONE. It changes only on IDLE->ISSUE.
//  tx_busy already high in IDLE: wait, no issue.
//  idle = empty && state==IDLE, registered.
// CONFIGURATION
//  UART_TXQ_LEVEL_EN defined:
//   - adds output port level [log2(DEPTH):0], equal to count (reset 0)
//   - adds output port almost_full, 1 when count >= DEPTH-2 (reset 0)
//  UART_TXQ_LEVEL_EN undefined:
//   - neither port exists; all other behaviour is identical
// TESTING
//  T1 reset: rst high 3 clk mid-transfer -> empty=1, tx_wr_en=0, tx_data=00, idle=1
//   next cycle.
//  T2 single byte: push 8'hA5, tx_busy=0 -> tx_wr_en pulse 2 clk later with tx_data=A5;
//   model busy high 10 clk -> exactly one issue, then idle=1.
//  T3 ordering: push 55,AA,0F,F0 back-to-back against the real uart_top ->
//   data_out receives 55,AA,0F,F0 in order, one tx_wr_en per byte.
//  T4 full/overflow (DEPTH=16): tx_busy held 1, push 17 bytes -> full=1 after 16th push;
//   17th byte pulses overflow and is dropped. Release busy -> exactly 16 bytes sent.
//  T5 timeout: tx_busy tied 0, push 3C -> tx_wr_en re-pulses every BUSY_TIMEOUT+1 clk
//   with tx_data=3C; count stays 1.
//  T6 push/pop same cycle: count=5, push on busy-rise cycle -> count stays 5, order kept;
//   with UART_TXQ_LEVEL_EN, level reads 5.

Source files
------------

// File: rtl/uart_tx_queue.sv
// rtl/uart_tx_queue.sv - byte FIFO and transmit sequencer feeding the UART wr_en/data_in/busy handshake
// Optional UART_TXQ_LEVEL_EN adds the level and almost_full outputs.
module uart_tx_queue #(
    parameter int DEPTH        = 16,
    parameter int BUSY_TIMEOUT = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [7:0]             push_data,
    output logic                   full,
    output logic                   empty,
    output logic                   overflow,
    output logic                   tx_wr_en,
    output logic [7:0]             tx_data,
    input  logic                   tx_busy,
`ifdef UART_TXQ_LEVEL_EN
    output logic [$clog2(DEPTH):0] level,
    output logic                   almost_full,
`endif
    output logic                   idle
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;

    localparam logic [CW-1:0] CNT_FULL   = CW'(DEPTH);
    localparam logic [TW-1:0] TIMER_LAST = TW'(BUSY_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_BUSY,
        S_WAIT_DONE
    } state_t;

    state_t        state;
    state_t        state_next;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic [TW-1:0] timer;

    logic          push_ok;
    logic          pop;
    logic          load_data;
    logic          timer_clr;
    logic          timer_inc;

    // full is the registered flag, so a push while full is dropped even if a pop lands this cycle
    assign push_ok = push && !full;

    always_comb begin
        count_next = count;
        case ({push_ok, pop})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count    <= count_next;
            full     <= (count_next == CNT_FULL);
            empty    <= (count_next == '0);
            overflow <= push && full;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // The head is only popped once the transmitter acknowledges it by raising busy
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        load_data  = 1'b0;
        timer_clr  = 1'b0;
        timer_inc  = 1'b0;
        case (state)
            S_IDLE: begin
                if (!empty && !tx_busy) begin
                    state_next = S_ISSUE;
                    load_data  = 1'b1;
                end
            end
            S_ISSUE: begin
                timer_clr  = 1'b1;
                state_next = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (tx_busy) begin
                    pop        = 1'b1;
                    state_next = S_WAIT_DONE;
                end else if (timer == TIMER_LAST) begin
                    state_next = S_ISSUE;
                end else begin
                    timer_inc = 1'b1;
                end
            end
            S_WAIT_DONE: begin
                if (!tx_busy) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            timer    <= '0;
            tx_wr_en <= 1'b0;
            tx_data  <= 8'h00;
            idle     <= 1'b1;
        end else begin
            state    <= state_next;
            tx_wr_en <= (state_next == S_ISSUE);
            idle     <= (count_next == '0) && (state_next == S_IDLE);
            if (load_data) begin
                tx_data <= mem[rd_ptr];
            end
            if (timer_clr) begin
                timer <= '0;
            end else if (timer_inc) begin
                timer <= timer + TW'(1);
            end
        end
    end

`ifdef UART_TXQ_LEVEL_EN
    localparam logic [CW-1:0] CNT_ALMOST = CW'(DEPTH - 2);

    assign level = count;

    always_ff @(posedge clk) begin
        if (rst) begin
            almost_full <= 1'b0;
        end else begin
            almost_full <= (count_next >= CNT_ALMOST);
        end
    end
`endif

endmodule
